// File: rtl/multicycle_sequencer.sv
// Sequencing FSM for the multicycle RISC-V datapath: FETCH/DECODE/EXEC/MEM/WB strobes.
// Latency: strobes are combinational from state; R/I/JAL 4, BRANCH 3, STORE 4+w, LOAD 5+w cycles.
// Backpressure: MEM holds the request until mem_ready; MEM_WAIT_MAX idle cycles -> sticky HALT.
module multicycle_sequencer #(
    parameter int COUNT_W      = 16,
    parameter int MEM_WAIT_MAX = 15
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               run,
    input  logic [6:0]         instr_opcode,
    input  logic [2:0]         ctl_alu_op,
    input  logic [1:0]         ctl_alu_src,
    input  logic               alu_zero,
    input  logic               mem_ready,
    output logic [2:0]         step,
    output logic               ir_write,
    output logic               pc_write,
    output logic [1:0]         pc_src,
    output logic               rf_we,
    output logic               mem_to_reg,
    output logic               dmem_re,
    output logic               dmem_we,
    output logic [2:0]         alu_op_q,
    output logic [1:0]         alu_src_q,
    output logic               illegal,
    output logic               bus_err,
    output logic [COUNT_W-1:0] retired
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_HALT   = 3'd7
    } state_t;

    typedef enum logic [2:0] {
        C_R      = 3'd0,
        C_I      = 3'd1,
        C_LOAD   = 3'd2,
        C_STORE  = 3'd3,
        C_BRANCH = 3'd4,
        C_JAL    = 3'd5,
        C_ILL    = 3'd6
    } cls_t;

    // Last non-ready MEM cycle index before the access is declared dead.
    localparam logic [7:0] WAIT_LAST = 8'(MEM_WAIT_MAX - 1);

    state_t     state;
    cls_t       cls_q;
    cls_t       cls_dec;
    logic [7:0] wait_cnt;
    logic       retire;
    logic       mem_timeout;

    assign step = state;

    // Classify the opcode; JALR and anything unknown fall to illegal.
    always_comb begin
        cls_dec = C_ILL;
        case (instr_opcode)
            7'b0110011: cls_dec = C_R;
            7'b0010011: cls_dec = C_I;
            7'b0000011: cls_dec = C_LOAD;
            7'b0100011: cls_dec = C_STORE;
            7'b1100011: cls_dec = C_BRANCH;
            7'b1101111: cls_dec = C_JAL;
            default:    cls_dec = C_ILL;
        endcase
    end

    assign retire = (state == S_EXEC && cls_q == C_BRANCH) ||
                    (state == S_MEM  && cls_q == C_STORE && mem_ready) ||
                    (state == S_WB);

    assign mem_timeout = (state == S_MEM) && !mem_ready && (wait_cnt == WAIT_LAST);

    // Per-cycle strobes from state and latched class; branch pc_src also follows alu_zero.
    always_comb begin
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        pc_src     = 2'b00;
        rf_we      = 1'b0;
        mem_to_reg = 1'b0;
        dmem_re    = 1'b0;
        dmem_we    = 1'b0;
        case (state)
            S_FETCH: ir_write = 1'b1;
            S_EXEC: begin
                if (cls_q == C_BRANCH) begin
                    pc_write = 1'b1;
                    pc_src   = alu_zero ? 2'b01 : 2'b00;
                end
            end
            S_MEM: begin
                dmem_re = (cls_q == C_LOAD);
                dmem_we = (cls_q == C_STORE);
                if (cls_q == C_STORE && mem_ready) begin
                    pc_write = 1'b1;
                end
            end
            S_WB: begin
                rf_we      = 1'b1;
                pc_write   = 1'b1;
                mem_to_reg = (cls_q == C_LOAD);
                pc_src     = (cls_q == C_JAL) ? 2'b10 : 2'b00;
            end
            default: ;
        endcase
    end

    // State transitions, latched decoder fields, sticky flags and counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            cls_q     <= C_R;
            alu_op_q  <= 3'd0;
            alu_src_q <= 2'd0;
            illegal   <= 1'b0;
            bus_err   <= 1'b0;
            retired   <= '0;
            wait_cnt  <= 8'd0;
        end else begin
            if (retire) begin
                retired <= retired + {{(COUNT_W-1){1'b0}}, 1'b1};
                state   <= run ? S_FETCH : S_IDLE;
            end else begin
                case (state)
                    S_IDLE:   if (run) state <= S_FETCH;
                    S_FETCH:  state <= S_DECODE;
                    S_DECODE: begin
                        alu_op_q  <= ctl_alu_op;
                        alu_src_q <= ctl_alu_src;
                        cls_q     <= cls_dec;
                        if (cls_dec == C_ILL) begin
                            state   <= S_HALT;
                            illegal <= 1'b1;
                        end else begin
                            state <= S_EXEC;
                        end
                    end
                    S_EXEC: begin
                        if (cls_q == C_LOAD || cls_q == C_STORE) begin
                            state    <= S_MEM;
                            wait_cnt <= 8'd0;
                        end else begin
                            state <= S_WB;
                        end
                    end
                    S_MEM: begin
                        if (mem_ready) begin
                            state <= S_WB;
                        end else if (mem_timeout) begin
                            state   <= S_HALT;
                            bus_err <= 1'b1;
                        end else begin
                            wait_cnt <= wait_cnt + 8'd1;
                        end
                    end
                    S_HALT:  state <= S_HALT;
                    default: state <= S_HALT;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Directed bench for multicycle_sequencer: vector table plus hand-written corner sequences.
// Inputs change at the falling edge; outputs are compared 1 ns later.
// Narrow retired counter so the wrap case is reachable in a short run.
module tb_multicycle_sequencer;

    localparam int CW = 4;
    localparam int MW = 15;

    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_I    = 7'b0010011;
    localparam logic [6:0] OP_LD   = 7'b0000011;
    localparam logic [6:0] OP_ST   = 7'b0100011;
    localparam logic [6:0] OP_BR   = 7'b1100011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;
    localparam logic [6:0] OP_JALR = 7'b1100111;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          run;
    logic [6:0]    instr_opcode;
    logic [2:0]    ctl_alu_op;
    logic [1:0]    ctl_alu_src;
    logic          alu_zero;
    logic          mem_ready;
    logic [2:0]    step;
    logic          ir_write, pc_write, rf_we, mem_to_reg, dmem_re, dmem_we;
    logic [1:0]    pc_src;
    logic [2:0]    alu_op_q;
    logic [1:0]    alu_src_q;
    logic          illegal, bus_err;
    logic [CW-1:0] retired;

    multicycle_sequencer #(.COUNT_W(CW), .MEM_WAIT_MAX(MW)) dut (
        .clk(clk), .rst_n(rst_n), .run(run), .instr_opcode(instr_opcode),
        .ctl_alu_op(ctl_alu_op), .ctl_alu_src(ctl_alu_src), .alu_zero(alu_zero),
        .mem_ready(mem_ready), .step(step), .ir_write(ir_write), .pc_write(pc_write),
        .pc_src(pc_src), .rf_we(rf_we), .mem_to_reg(mem_to_reg), .dmem_re(dmem_re),
        .dmem_we(dmem_we), .alu_op_q(alu_op_q), .alu_src_q(alu_src_q),
        .illegal(illegal), .bus_err(bus_err), .retired(retired)
    );

    always #5 clk = ~clk;

    // {step, ir_write, pc_write, pc_src, rf_we, mem_to_reg, dmem_re, dmem_we, alu_op_q, alu_src_q, retired}
    logic [19:0] obs;
    logic [7:0]  strobes;
    assign obs     = {step, ir_write, pc_write, pc_src, rf_we, mem_to_reg, dmem_re, dmem_we,
                      alu_op_q, alu_src_q, retired};
    assign strobes = {ir_write, pc_write, pc_src, rf_we, mem_to_reg, dmem_re, dmem_we};

    typedef struct packed {
        logic        run;
        logic [6:0]  opc;
        logic [2:0]  aop;
        logic [1:0]  asrc;
        logic        zero;
        logic        mrdy;
        logic [19:0] exp;
    } vec_t;

    vec_t tbl[$];
    int   n_chk  = 0;
    int   n_fail = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input logic r, input logic [6:0] opc, input logic [2:0] aop,
                                input logic [1:0] asrc, input logic z, input logic mr,
                                input logic [2:0] st, input logic irw, input logic pcw,
                                input logic [1:0] pcs, input logic rfwe, input logic m2r,
                                input logic re, input logic we, input logic [2:0] aopq,
                                input logic [1:0] asrcq, input logic [CW-1:0] ret);
        vec_t v;
        v.run  = r;   v.opc  = opc; v.aop = aop; v.asrc = asrc;
        v.zero = z;   v.mrdy = mr;
        v.exp  = {st, irw, pcw, pcs, rfwe, m2r, re, we, aopq, asrcq, ret};
        return v;
    endfunction

    task automatic go(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt;
        int guard;

        //          run opc    aop   asrc  z  mr   st irw pcw pcs  rf m2r re we aopq  asrcq ret
        tbl.push_back(mk(0, OP_R,  3'd2, 2'd0, 0, 0,  0, 0, 0, 2'd0, 0, 0, 0, 0, 3'd0, 2'd0, 0));
        tbl.push_back(mk(1, OP_R,  3'd2, 2'd0, 0, 0,  0, 0, 0, 2'd0, 0, 0, 0, 0, 3'd0, 2'd0, 0));
        tbl.push_back(mk(1, OP_R,  3'd2, 2'd0, 0, 0,  1, 1, 0, 2'd0, 0, 0, 0, 0, 3'd0, 2'd0, 0));
        tbl.push_back(mk(1, OP_R,  3'd2, 2'd0, 0, 0,  2, 0, 0, 2'd0, 0, 0, 0, 0, 3'd0, 2'd0, 0));
        tbl.push_back(mk(1, OP_R,  3'd2, 2'd0, 0, 0,  3, 0, 0, 2'd0, 0, 0, 0, 0, 3'd2, 2'd0, 0));
        tbl.push_back(mk(1, OP_R,  3'd2, 2'd0, 0, 0,  5, 0, 1, 2'd0, 1, 0, 0, 0, 3'd2, 2'd0, 0));
        tbl.push_back(mk(1, OP_I,  3'd3, 2'd1, 0, 0,  1, 1, 0, 2'd0, 0, 0, 0, 0, 3'd2, 2'd0, 1));
        tbl.push_back(mk(1, OP_I,  3'd3, 2'd1, 0, 0,  2, 0, 0, 2'd0, 0, 0, 0, 0, 3'd2, 2'd0, 1));
        tbl.push_back(mk(1, OP_I,  3'd3, 2'd1, 0, 0,  3, 0, 0, 2'd0, 0, 0, 0, 0, 3'd3, 2'd1, 1));
        tbl.push_back(mk(1, OP_I,  3'd3, 2'd1, 0, 0,  5, 0, 1, 2'd0, 1, 0, 0, 0, 3'd3, 2'd1, 1));
        tbl.push_back(mk(1, OP_JAL,3'd0, 2'd2, 0, 0,  1, 1, 0, 2'd0, 0, 0, 0, 0, 3'd3, 2'd1, 2));
        tbl.push_back(mk(1, OP_JAL,3'd0, 2'd2, 0, 0,  2, 0, 0, 2'd0, 0, 0, 0, 0, 3'd3, 2'd1, 2));
        tbl.push_back(mk(1, OP_JAL,3'd0, 2'd2, 0, 0,  3, 0, 0, 2'd0, 0, 0, 0, 0, 3'd0, 2'd2, 2));
        tbl.push_back(mk(1, OP_JAL,3'd0, 2'd2, 0, 0,  5, 0, 1, 2'd2, 1, 0, 0, 0, 3'd0, 2'd2, 2));
        tbl.push_back(mk(1, OP_BR, 3'd1, 2'd0, 1, 0,  1, 1, 0, 2'd0, 0, 0, 0, 0, 3'd0, 2'd2, 3));
        tbl.push_back(mk(1, OP_BR, 3'd1, 2'd0, 1, 0,  2, 0, 0, 2'd0, 0, 0, 0, 0, 3'd0, 2'd2, 3));
        tbl.push_back(mk(1, OP_BR, 3'd1, 2'd0, 1, 0,  3, 0, 1, 2'd1, 0, 0, 0, 0, 3'd1, 2'd0, 3));
        tbl.push_back(mk(1, OP_BR, 3'd1, 2'd0, 0, 0,  1, 1, 0, 2'd0, 0, 0, 0, 0, 3'd1, 2'd0, 4));
        tbl.push_back(mk(1, OP_BR, 3'd1, 2'd0, 0, 0,  2, 0, 0, 2'd0, 0, 0, 0, 0, 3'd1, 2'd0, 4));
        tbl.push_back(mk(1, OP_BR, 3'd1, 2'd0, 0, 0,  3, 0, 1, 2'd0, 0, 0, 0, 0, 3'd1, 2'd0, 4));
        tbl.push_back(mk(1, OP_LD, 3'd0, 2'd1, 0, 1,  1, 1, 0, 2'd0, 0, 0, 0, 0, 3'd1, 2'd0, 5));
        tbl.push_back(mk(1, OP_LD, 3'd0, 2'd1, 0, 1,  2, 0, 0, 2'd0, 0, 0, 0, 0, 3'd1, 2'd0, 5));
        tbl.push_back(mk(1, OP_LD, 3'd0, 2'd1, 0, 1,  3, 0, 0, 2'd0, 0, 0, 0, 0, 3'd0, 2'd1, 5));
        tbl.push_back(mk(1, OP_LD, 3'd0, 2'd1, 0, 0,  4, 0, 0, 2'd0, 0, 0, 1, 0, 3'd0, 2'd1, 5));
        tbl.push_back(mk(1, OP_LD, 3'd0, 2'd1, 0, 0,  4, 0, 0, 2'd0, 0, 0, 1, 0, 3'd0, 2'd1, 5));
        tbl.push_back(mk(1, OP_LD, 3'd0, 2'd1, 0, 0,  4, 0, 0, 2'd0, 0, 0, 1, 0, 3'd0, 2'd1, 5));
        tbl.push_back(mk(1, OP_LD, 3'd0, 2'd1, 0, 1,  4, 0, 0, 2'd0, 0, 0, 1, 0, 3'd0, 2'd1, 5));
        tbl.push_back(mk(1, OP_LD, 3'd0, 2'd1, 0, 0,  5, 0, 1, 2'd0, 1, 1, 0, 0, 3'd0, 2'd1, 5));
        tbl.push_back(mk(1, OP_ST, 3'd0, 2'd1, 0, 0,  1, 1, 0, 2'd0, 0, 0, 0, 0, 3'd0, 2'd1, 6));
        tbl.push_back(mk(1, OP_ST, 3'd0, 2'd1, 0, 0,  2, 0, 0, 2'd0, 0, 0, 0, 0, 3'd0, 2'd1, 6));
        tbl.push_back(mk(1, OP_ST, 3'd0, 2'd1, 0, 0,  3, 0, 0, 2'd0, 0, 0, 0, 0, 3'd0, 2'd1, 6));
        tbl.push_back(mk(1, OP_ST, 3'd0, 2'd1, 0, 0,  4, 0, 0, 2'd0, 0, 0, 0, 1, 3'd0, 2'd1, 6));
        tbl.push_back(mk(0, OP_ST, 3'd0, 2'd1, 0, 1,  4, 0, 1, 2'd0, 0, 0, 0, 1, 3'd0, 2'd1, 6));
        tbl.push_back(mk(0, OP_ST, 3'd0, 2'd1, 0, 0,  0, 0, 0, 2'd0, 0, 0, 0, 0, 3'd0, 2'd1, 7));

        rst_n = 1'b0; run = 1'b0; instr_opcode = OP_R; ctl_alu_op = 3'd0;
        ctl_alu_src = 2'd0; alu_zero = 1'b0; mem_ready = 1'b0;
        go(2);
        #1;
        chk("reset_outputs", 32'(obs), 32'd0);
        chk("reset_flags", {30'd0, illegal, bus_err}, 32'd0);
        go(1);
        rst_n = 1'b1;

        // Table: R, I, JAL, two branches, LOAD with 3 waits, STORE with 1 wait then run low.
        foreach (tbl[i]) begin
            run = tbl[i].run; instr_opcode = tbl[i].opc; ctl_alu_op = tbl[i].aop;
            ctl_alu_src = tbl[i].asrc; alu_zero = tbl[i].zero; mem_ready = tbl[i].mrdy;
            #1;
            chk($sformatf("vec%0d", i), 32'(obs), 32'(tbl[i].exp));
            go(1);
        end

        // JALR is illegal: DECODE then sticky HALT, nothing moves for 20 cycles.
        run = 1'b1; instr_opcode = OP_JALR; mem_ready = 1'b0;
        go(2);
        #1 chk("illegal_decode_step", 32'(step), 32'd2);
        go(1);
        #1 chk("illegal_halt", {28'd0, step, illegal}, {28'd0, 3'd7, 1'b1});
        for (int k = 0; k < 20; k++) begin
            run = k[0]; mem_ready = ~k[0]; instr_opcode = OP_R;
            go(1);
            #1 chk($sformatf("halt_quiet%0d", k), {17'd0, step, strobes, retired, bus_err},
                   {17'd0, 3'd7, 8'd0, 4'd7, 1'b0});
        end
        rst_n = 1'b0;
        #1 chk("illegal_reset", {26'd0, step, illegal, retired}, 32'd0);
        go(1);
        rst_n = 1'b1;

        // STORE with mem_ready stuck low: request held MW cycles, then bus error.
        run = 1'b1; instr_opcode = OP_ST; mem_ready = 1'b0;
        go(4);
        #1;
        cnt = 0; guard = 0;
        while (step == 3'd4 && guard < 300) begin
            if (dmem_we) cnt++;
            guard++;
            go(1);
            #1;
        end
        chk("timeout_we_cycles", 32'(cnt), 32'(MW));
        chk("timeout_halt", {26'd0, step, dmem_we, bus_err, illegal}, {26'd0, 3'd7, 1'b0, 1'b1, 1'b0});
        rst_n = 1'b0;
        #1 chk("timeout_reset", {30'd0, bus_err, illegal}, 32'd0);
        go(1);
        rst_n = 1'b1;

        // Async reset during a LOAD's MEM cycle drops the request immediately.
        run = 1'b1; instr_opcode = OP_R; mem_ready = 1'b0;
        go(5);
        #1 chk("pre_load_retired", {25'd0, step, retired}, {25'd0, 3'd1, 4'd1});
        instr_opcode = OP_LD;
        go(3);
        #1 chk("load_mem_re", {28'd0, step, dmem_re}, {28'd0, 3'd4, 1'b1});
        #1 rst_n = 1'b0;
        #1 chk("mid_mem_reset", {24'd0, step, dmem_re, retired}, 32'd0);
        go(1);
        rst_n = 1'b1;

        // run dropped in EXEC of an R-type: instruction still completes, then IDLE.
        run = 1'b1; instr_opcode = OP_R;
        go(3);
        run = 1'b0;
        #1 chk("rundrop_exec", 32'(step), 32'd3);
        go(1);
        #1 chk("rundrop_wb", {27'd0, step, rf_we, pc_write}, {27'd0, 3'd5, 1'b1, 1'b1});
        go(1);
        #1 chk("rundrop_idle", {25'd0, step, retired}, {25'd0, 3'd0, 4'd1});
        go(1);
        #1 chk("rundrop_stay", 32'(step), 32'd0);

        // Retired counter wraps from all-ones to zero.
        run = 1'b1; instr_opcode = OP_BR; alu_zero = 1'b0;
        go(1 + 3 * 14);
        #1 chk("count_15", {25'd0, step, retired}, {25'd0, 3'd1, 4'd15});
        go(3);
        #1 chk("count_wrap", {25'd0, step, retired}, {25'd0, 3'd1, 4'd0});

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
